// File: rtl/mem_access_stage.sv
// Pipeline memory stage: takes the EX/MEM bundle, performs aligned sub-word loads and
// stores over a valid/ready data-memory port, and drives the MEM/WB register and forwarding bus.
module mem_access_stage #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_ready,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [5:0]        ex_rd,
    input  logic              ex_mem_active,
    input  logic              ex_load,
    input  logic [7:0]        ex_size,
    input  logic              ex_unsign,
    input  logic              ex_wbactive,
    input  logic              ex_ecall,
    output logic              mem_stall,
    output logic [5:0]        fwd_rd,
    output logic [DATA_W-1:0] fwd_val,
    output logic              fwd_wbactive,
    output logic              dmem_req_valid,
    input  logic              dmem_req_ready,
    output logic              dmem_req_we,
    output logic [ADDR_W-1:0] dmem_req_addr,
    output logic [DATA_W-1:0] dmem_req_wdata,
    output logic [7:0]        dmem_req_be,
    input  logic              dmem_resp_valid,
    input  logic [DATA_W-1:0] dmem_resp_rdata,
    output logic              wb_ready,
    output logic [5:0]        wb_rd,
    output logic [DATA_W-1:0] wb_val,
    output logic              wb_wbactive,
    output logic              wb_ecall,
    output logic              wb_fault
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [5:0]        rd_q, rd_d;
    logic [7:0]        size_q, size_d;
    logic              unsign_q, unsign_d;
    logic              load_q, load_d;
    logic              wbactive_q, wbactive_d;

    logic              wb_ready_q, wb_ready_d;
    logic [5:0]        wb_rd_q, wb_rd_d;
    logic [DATA_W-1:0] wb_val_q, wb_val_d;
    logic              wb_wbactive_q, wb_wbactive_d;
    logic              wb_ecall_q, wb_ecall_d;
    logic              wb_fault_q, wb_fault_d;

    logic              size_ok;
    logic              misalign;
    logic              done;
    logic [7:0]        size_mask;
    logic [DATA_W-1:0] shifted_rdata;
    logic [DATA_W-1:0] load_val;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            data_q        <= '0;
            rd_q          <= '0;
            size_q        <= '0;
            unsign_q      <= 1'b0;
            load_q        <= 1'b0;
            wbactive_q    <= 1'b0;
            wb_ready_q    <= 1'b0;
            wb_rd_q       <= '0;
            wb_val_q      <= '0;
            wb_wbactive_q <= 1'b0;
            wb_ecall_q    <= 1'b0;
            wb_fault_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            rd_q          <= rd_d;
            size_q        <= size_d;
            unsign_q      <= unsign_d;
            load_q        <= load_d;
            wbactive_q    <= wbactive_d;
            wb_ready_q    <= wb_ready_d;
            wb_rd_q       <= wb_rd_d;
            wb_val_q      <= wb_val_d;
            wb_wbactive_q <= wb_wbactive_d;
            wb_ecall_q    <= wb_ecall_d;
            wb_fault_q    <= wb_fault_d;
        end
    end

    // Size legality and natural alignment of the incoming address.
    always_comb begin
        size_ok  = 1'b0;
        misalign = 1'b0;
        case (ex_size)
            8'd8:  size_ok = 1'b1;
            8'd16: begin size_ok = 1'b1; misalign = ex_result[0];     end
            8'd32: begin size_ok = 1'b1; misalign = |ex_result[1:0];  end
            8'd64: begin size_ok = 1'b1; misalign = |ex_result[2:0];  end
            default: ;
        endcase
    end

    // Load data path: bring the addressed lane down to bit 0, then extend.
    always_comb begin
        shifted_rdata = dmem_resp_rdata >> {addr_q[2:0], 3'b000};
        case (size_q)
            8'd8:    load_val = {{(DATA_W-8){shifted_rdata[7] & ~unsign_q}},   shifted_rdata[7:0]};
            8'd16:   load_val = {{(DATA_W-16){shifted_rdata[15] & ~unsign_q}}, shifted_rdata[15:0]};
            8'd32:   load_val = {{(DATA_W-32){shifted_rdata[31] & ~unsign_q}}, shifted_rdata[31:0]};
            default: load_val = shifted_rdata;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        data_d        = data_q;
        rd_d          = rd_q;
        size_d        = size_q;
        unsign_d      = unsign_q;
        load_d        = load_q;
        wbactive_d    = wbactive_q;
        wb_ready_d    = wb_ready_q;
        wb_rd_d       = wb_rd_q;
        wb_val_d      = wb_val_q;
        wb_wbactive_d = wb_wbactive_q;
        wb_ecall_d    = wb_ecall_q;
        wb_fault_d    = wb_fault_q;
        done          = 1'b0;

        case (state_q)
            IDLE: begin
                if (ex_ready && ex_mem_active) begin
                    addr_d        = ex_result[ADDR_W-1:0];
                    data_d        = ex_store_data;
                    rd_d          = ex_rd;
                    size_d        = ex_size;
                    unsign_d      = ex_unsign;
                    load_d        = ex_load;
                    wbactive_d    = ex_wbactive;
                    wb_rd_d       = ex_rd;
                    wb_wbactive_d = 1'b0;
                    wb_ecall_d    = 1'b0;
                    if (!size_ok || misalign) begin
                        // Faulting access completes immediately without touching memory.
                        wb_ready_d = 1'b1;
                        wb_fault_d = 1'b1;
                        wb_val_d   = '0;
                    end else begin
                        state_d    = REQ;
                        wb_ready_d = 1'b0;
                        wb_fault_d = 1'b0;
                    end
                end else if (ex_ready) begin
                    wb_ready_d    = 1'b1;
                    wb_rd_d       = ex_rd;
                    wb_val_d      = ex_result;
                    wb_wbactive_d = ex_wbactive && (ex_rd != 6'd0);
                    wb_ecall_d    = ex_ecall;
                    wb_fault_d    = 1'b0;
                end else begin
                    wb_ready_d    = 1'b0;
                    wb_wbactive_d = 1'b0;
                    wb_ecall_d    = 1'b0;
                    wb_fault_d    = 1'b0;
                end
            end
            REQ: begin
                if (dmem_req_ready) begin
                    if (dmem_resp_valid) begin
                        done = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (dmem_resp_valid) begin
                    done = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (done) begin
            state_d       = IDLE;
            wb_ready_d    = 1'b1;
            wb_rd_d       = rd_q;
            wb_val_d      = load_q ? load_val : '0;
            wb_wbactive_d = load_q && wbactive_q && (rd_q != 6'd0);
            wb_ecall_d    = 1'b0;
            wb_fault_d    = 1'b0;
        end
    end

    always_comb begin
        case (size_q)
            8'd8:    size_mask = 8'h01;
            8'd16:   size_mask = 8'h03;
            8'd32:   size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    end

    // Request fields are only presented while a request is pending, so they read 0 otherwise.
    assign dmem_req_valid = (state_q == REQ);
    assign dmem_req_we    = dmem_req_valid && !load_q;
    assign dmem_req_addr  = dmem_req_valid ? {addr_q[ADDR_W-1:3], 3'b000} : '0;
    assign dmem_req_wdata = dmem_req_valid ? (data_q << {addr_q[2:0], 3'b000}) : '0;
    assign dmem_req_be    = dmem_req_valid ? (size_mask << addr_q[2:0]) : 8'h00;

    assign mem_stall    = (state_q != IDLE);

    assign wb_ready     = wb_ready_q;
    assign wb_rd        = wb_rd_q;
    assign wb_val       = wb_val_q;
    assign wb_wbactive  = wb_wbactive_q;
    assign wb_ecall     = wb_ecall_q;
    assign wb_fault     = wb_fault_q;

    assign fwd_rd       = wb_rd_q;
    assign fwd_val      = wb_val_q;
    assign fwd_wbactive = wb_ready_q && wb_wbactive_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage against a byte-arithmetic reference model,
// plus directed pass-through, sub-word load/store, fault and reset-abort scenarios.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_ready;
    logic [63:0] ex_result;
    logic [63:0] ex_store_data;
    logic [5:0]  ex_rd;
    logic        ex_mem_active;
    logic        ex_load;
    logic [7:0]  ex_size;
    logic        ex_unsign;
    logic        ex_wbactive;
    logic        ex_ecall;
    logic        mem_stall;
    logic [5:0]  fwd_rd;
    logic [63:0] fwd_val;
    logic        fwd_wbactive;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic        dmem_req_we;
    logic [63:0] dmem_req_addr;
    logic [63:0] dmem_req_wdata;
    logic [7:0]  dmem_req_be;
    logic        dmem_resp_valid;
    logic [63:0] dmem_resp_rdata;
    logic        wb_ready;
    logic [5:0]  wb_rd;
    logic [63:0] wb_val;
    logic        wb_wbactive;
    logic        wb_ecall;
    logic        wb_fault;

    int total = 0;
    int bad   = 0;
    int txn   = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk(clk), .reset(reset),
        .ex_ready(ex_ready), .ex_result(ex_result), .ex_store_data(ex_store_data),
        .ex_rd(ex_rd), .ex_mem_active(ex_mem_active), .ex_load(ex_load),
        .ex_size(ex_size), .ex_unsign(ex_unsign), .ex_wbactive(ex_wbactive),
        .ex_ecall(ex_ecall), .mem_stall(mem_stall),
        .fwd_rd(fwd_rd), .fwd_val(fwd_val), .fwd_wbactive(fwd_wbactive),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_req_we(dmem_req_we), .dmem_req_addr(dmem_req_addr),
        .dmem_req_wdata(dmem_req_wdata), .dmem_req_be(dmem_req_be),
        .dmem_resp_valid(dmem_resp_valid), .dmem_resp_rdata(dmem_resp_rdata),
        .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_val(wb_val),
        .wb_wbactive(wb_wbactive), .wb_ecall(wb_ecall), .wb_fault(wb_fault)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One instruction through the stage; memory timing is scripted by rdly/pdly.
    task automatic do_op(input bit mem, input bit ld, input logic [63:0] res,
                         input logic [63:0] sd, input logic [5:0] rd, input logic [7:0] size,
                         input bit uns, input bit wba, input bit ec,
                         input int rdly, input int pdly, input logic [63:0] rdata);
        int          nb;
        int          off;
        bit          legal;
        bit          fault;
        logic [63:0] mask;
        logic [63:0] raw;
        logic [63:0] exp_val;
        logic [63:0] exp_wd;
        logic [63:0] exp_addr;
        logic [7:0]  exp_be;
        int          bem;
        bit          exp_wba;

        nb    = int'(size) / 8;
        legal = (size == 8'd8) || (size == 8'd16) || (size == 8'd32) || (size == 8'd64);
        off   = int'(res % 64'd8);
        fault = mem && (!legal || (res % 64'(nb)) != 64'd0);
        exp_addr = res - 64'(off);
        bem      = ((1 << nb) - 1) << off;
        exp_be   = bem[7:0];
        exp_wd   = sd << (8 * off);
        raw      = rdata >> (8 * off);
        if (nb < 8) begin
            mask    = (64'd1 << (8 * nb)) - 64'd1;
            exp_val = raw & mask;
            if (!uns && raw[8*nb-1]) exp_val = exp_val | ~mask;
        end else begin
            exp_val = raw;
        end
        if (!mem)       exp_wba = wba && (rd != 6'd0);
        else if (fault) exp_wba = 1'b0;
        else            exp_wba = ld && wba && (rd != 6'd0);

        chk("stall_before_issue", mem_stall, 0);
        ex_ready = 1; ex_result = res; ex_store_data = sd; ex_rd = rd;
        ex_mem_active = mem; ex_load = ld; ex_size = size; ex_unsign = uns;
        ex_wbactive = wba; ex_ecall = ec;
        tick();
        ex_ready = 0; ex_mem_active = 0;
        ex_result = 64'($urandom);

        if (mem && !fault) begin
            chk("wb_ready_on_issue", wb_ready, 0);
            for (int i = 0; i <= rdly; i++) begin
                chk("stall_req", mem_stall, 1);
                chk("req_valid", dmem_req_valid, 1);
                chk("req_addr", dmem_req_addr, exp_addr);
                chk("req_be", 64'(dmem_req_be), 64'(exp_be));
                chk("req_we", dmem_req_we, !ld);
                if (!ld) chk("req_wdata", dmem_req_wdata, exp_wd);
                if (i == rdly) begin
                    dmem_req_ready  = 1;
                    dmem_resp_valid = (pdly == 0);
                    dmem_resp_rdata = rdata;
                end else begin
                    dmem_resp_valid = 1'($urandom % 2);
                    dmem_resp_rdata = {$urandom, $urandom};
                end
                tick();
            end
            dmem_req_ready = 0;
            if (pdly > 0) begin
                dmem_resp_valid = 0;
                for (int i = 1; i < pdly; i++) begin
                    chk("stall_wait", mem_stall, 1);
                    chk("req_valid_wait", dmem_req_valid, 0);
                    chk("wb_ready_wait", wb_ready, 0);
                    tick();
                end
                chk("stall_last_wait", mem_stall, 1);
                dmem_resp_valid = 1;
                dmem_resp_rdata = rdata;
                tick();
            end
            dmem_resp_valid = 0;
            dmem_resp_rdata = {$urandom, $urandom};
        end

        chk("stall_done", mem_stall, 0);
        chk("req_valid_done", dmem_req_valid, 0);
        chk("wb_ready", wb_ready, 1);
        chk("wb_fault", wb_fault, fault);
        chk("wb_wbactive", wb_wbactive, exp_wba);
        chk("fwd_wbactive", fwd_wbactive, exp_wba);
        chk("wb_rd", 64'(wb_rd), 64'(rd));
        chk("fwd_rd", 64'(fwd_rd), 64'(rd));
        if (!mem) begin
            chk("wb_val_pass", wb_val, res);
            chk("wb_ecall", wb_ecall, ec);
        end else if (ld && !fault) begin
            chk("wb_val_load", wb_val, exp_val);
            chk("fwd_val_load", fwd_val, exp_val);
        end
        txn++;
        $display("txn %0d mem=%0d ld=%0d size=%0d addr=%h fault=%0d wb_val=%h wbact=%0d",
                 txn, mem, ld, size, res, fault, wb_val, wb_wbactive);
    endtask

    task automatic idle_cycle();
        tick();
        chk("idle_wb_ready", wb_ready, 0);
        chk("idle_fwd_wbactive", fwd_wbactive, 0);
    endtask

    initial begin
        logic [7:0]  sizes [6];
        logic [7:0]  sz;
        logic [63:0] a;
        int          nbr;
        sizes[0] = 8'd8; sizes[1] = 8'd16; sizes[2] = 8'd32;
        sizes[3] = 8'd64; sizes[4] = 8'd24; sizes[5] = 8'd0;

        reset = 1; ex_ready = 0; ex_result = 0; ex_store_data = 0; ex_rd = 0;
        ex_mem_active = 0; ex_load = 0; ex_size = 0; ex_unsign = 0;
        ex_wbactive = 0; ex_ecall = 0; dmem_req_ready = 0;
        dmem_resp_valid = 0; dmem_resp_rdata = 0;
        tick(); tick();
        chk("rst_stall", mem_stall, 0);
        chk("rst_wb_ready", wb_ready, 0);
        chk("rst_wb_val", wb_val, 0);
        chk("rst_req_valid", dmem_req_valid, 0);
        chk("rst_req_be", 64'(dmem_req_be), 0);
        chk("rst_fwd_wbactive", fwd_wbactive, 0);
        reset = 0;
        tick();

        // Directed scenarios.
        do_op(0, 0, 64'h1234, 0, 6'd5, 8'd64, 0, 1, 0, 0, 0, 0);
        do_op(1, 1, 64'h1003, 0, 6'd7, 8'd8, 0, 1, 0, 0, 1, 64'h00000000_80000000);
        chk("lb_value", wb_val, 64'hFFFFFFFF_FFFFFF80);
        do_op(1, 1, 64'h1003, 0, 6'd7, 8'd8, 1, 1, 0, 1, 0, 64'h00000000_80000000);
        chk("lbu_value", wb_val, 64'h80);
        do_op(1, 0, 64'h2006, 64'hBEEF, 6'd0, 8'd16, 0, 0, 0, 3, 2, 0);
        do_op(1, 1, 64'h3002, 0, 6'd9, 8'd32, 0, 1, 0, 0, 0, 0);
        do_op(1, 1, 64'h5000, 0, 6'd0, 8'd64, 0, 1, 0, 0, 1, 64'hCAFE);
        chk("rd0_wb_val", wb_val, 64'hCAFE);
        do_op(0, 0, 64'h77, 0, 6'd3, 8'd8, 0, 0, 1, 0, 0, 0);
        idle_cycle();

        // Reset while an ld waits for its response; the late response must be ignored.
        ex_ready = 1; ex_mem_active = 1; ex_load = 1; ex_result = 64'h4000;
        ex_size = 8'd64; ex_rd = 6'd4; ex_wbactive = 1; ex_unsign = 0;
        tick();
        ex_ready = 0; ex_mem_active = 0;
        dmem_req_ready = 1;
        tick();
        dmem_req_ready = 0;
        tick();
        reset = 1;
        tick();
        reset = 0;
        chk("rst_mid_stall", mem_stall, 0);
        chk("rst_mid_req_valid", dmem_req_valid, 0);
        chk("rst_mid_req_be", 64'(dmem_req_be), 0);
        chk("rst_mid_wb_ready", wb_ready, 0);
        chk("rst_mid_wb_val", wb_val, 0);
        chk("rst_mid_fwd", fwd_wbactive, 0);
        tick();
        dmem_resp_valid = 1; dmem_resp_rdata = 64'hDEAD_BEEF;
        tick();
        dmem_resp_valid = 0;
        chk("late_resp_stall", mem_stall, 0);
        chk("late_resp_wb_ready", wb_ready, 0);
        do_op(0, 0, 64'hABCD, 0, 6'd12, 8'd64, 0, 1, 0, 0, 0, 0);

        // Randomized mix of pass-through, loads, stores and faulting accesses.
        for (int n = 0; n < 150; n++) begin
            int kind;
            kind = int'($urandom_range(0, 9));
            sz   = sizes[(kind == 9) ? $urandom_range(4, 5) : $urandom_range(0, 3)];
            nbr  = int'(sz) / 8;
            a    = {32'h0, $urandom};
            if (nbr > 0 && $urandom_range(0, 3) != 0) a = a & ~64'(nbr - 1);
            do_op(kind >= 3, $urandom_range(0, 1) == 1, a, {$urandom, $urandom},
                  6'($urandom_range(0, 63)), sz, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 3) != 0, (kind < 3) && ($urandom_range(0, 3) == 0),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  {$urandom, $urandom});
            if ($urandom_range(0, 4) == 0) idle_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
Pipeline memory stage, directly downstream of the execute stage. Consumes the EX/MEM bundle: address or ALU result, store data, destination register, load/store controls, size, unsigned flag, writeback-active and ecall. Performs aligned sub-word loads and stores over a valid/ready data-memory port, stalls execute while an access is outstanding, and drives the MEM/WB register plus the MEM->EX forwarding bus.

Parameters:
ADDR_W, 64, address width
DATA_W, 64, data width; the memory word is 8 bytes

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ex_ready  in  1  EX/MEM bundle valid this cycle
ex_result  in  64  ALU result or effective address
ex_store_data  in  64  store source value (rs2)
ex_rd  in  6  destination register
ex_mem_active  in  1  instruction accesses memory
ex_load  in  1  1 = load, 0 = store (qualified by ex_mem_active)
ex_size  in  8  access size in bits: 8, 16, 32 or 64
ex_unsign  in  1  zero-extend load result
ex_wbactive  in  1  instruction writes a register
ex_ecall  in  1  ecall marker
mem_stall  out  1  to EX: hold the current EX instruction
fwd_rd  out  6  forwarding destination register
fwd_val  out  64  forwarding value
fwd_wbactive  out  1  forwarding entry valid
dmem_req_valid  out  1  memory request valid
dmem_req_ready  in  1  memory accepts request
dmem_req_we  out  1  write request
dmem_req_addr  out  64  8-byte-aligned address ({addr[63:3],3'b0})
dmem_req_wdata  out  64  lane-shifted store data
dmem_req_be  out  8  byte enables
dmem_resp_valid  in  1  read or write completion
dmem_resp_rdata  in  64  read data, full 8-byte word
wb_ready  out  1  MEM/WB valid
wb_rd  out  6  writeback register
wb_val  out  64  writeback value
wb_wbactive  out  1  writeback enable
wb_ecall  out  1  ecall passed to WB
wb_fault  out  1  misaligned access or illegal size

Behaviour:
- Reset: FSM -> IDLE. All outputs 0: mem_stall, wb_*, fwd_*, and dmem_req_* including be.
- FSM states: IDLE, REQ, WAIT.
- IDLE, no memory op:
  - If ex_ready && !ex_mem_active, register the bundle into MEM/WB next edge: wb_val=ex_result, wb_ready=1. Latency is 1 cycle.
  - If !ex_ready, wb_ready=0 next edge.
- IDLE, memory op (ex_ready && ex_mem_active):
  - Latch addr, data, rd, size, unsign, load.
  - Fault check: size not in {8,16,32,64}, or addr not size-aligned (addr[0] for 16, addr[1:0] for 32, addr[2:0] for 64). On fault, issue no request; the next edge sets wb_ready=1, wb_fault=1, wb_wbactive=0.
  - Otherwise go to REQ. wb_ready=0 that edge.
- REQ: dmem_req_valid=1 with stable fields until dmem_req_ready. On handshake go to WAIT.
  - be = size mask (8'h01/03/0F/FF) << addr[2:0].
  - wdata = store_data << (8*addr[2:0]).
  - we = !load.
  - If dmem_resp_valid arrives in the same cycle as the handshake, complete directly and skip WAIT.
- WAIT: on dmem_resp_valid, return to IDLE and register the result to MEM/WB.
  - Load: shift rdata right by 8*addr[2:0], truncate to size, then sign- or zero-extend per unsign. size 64 ignores unsign.
  - Store: wb_wbactive=0.
- mem_stall = (state != IDLE), combinational. While stalled, EX holds its instruction and MEM ignores ex_*. The cycle the FSM returns to IDLE, mem_stall=0 and the held EX instruction is accepted the following edge.
- wb_wbactive = latched wbactive && (rd != 0) && !fault.
- fwd_rd=wb_rd, fwd_val=wb_val, fwd_wbactive=wb_ready && wb_wbactive. An in-flight load never forwards.
- wb_ecall passes through with 1-cycle latency; ecall never accesses memory.
- Reset mid-access (REQ/WAIT): immediate return to IDLE, request dropped. A later dmem_resp_valid is ignored in IDLE.
- dmem_resp_valid in IDLE or REQ-before-handshake: ignored.

Test Plan:
- Pass-through: add with result 0x1234, rd=5, wbactive=1 -> next cycle wb_ready=1, wb_val=0x1234, fwd_wbactive=1, mem_stall never high.
- lb at addr 0x1003, rdata=0x00000000_80000000 -> wb_val=0xFFFFFFFF_FFFFFF80. Same access as lbu -> 0x80.
- sh of 0xBEEF at addr 0x2006, req_ready delayed 3 cycles -> mem_stall high throughout; req addr=0x2000, be=8'hC0, wdata=0xBEEF0000_00000000; wb_wbactive=0.
- lw at addr 0x3002 (misaligned) -> no dmem_req_valid; wb_fault=1 next cycle; mem_stall=0.
- ld with response 5 cycles after handshake, reset asserted in cycle 3 -> all outputs 0. The late response is ignored and the next add passes through normally.
- Load to rd=0 -> wb_wbactive=0 and fwd_wbactive=0, even though wb_val carries the data.
